// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at the tail, execution units mark
// entries done by tag, and the head entry retires into the register file write port.
module reorder_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [REG_AW-1:0]        alloc_dest,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     wb_valid,
  input  logic [$clog2(DEPTH)-1:0] wb_tag,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     commit_we,
  output logic [REG_AW-1:0]        commit_reg,
  output logic [DATA_W-1:0]        commit_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [REG_AW-1:0] r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [IW:0]       r_head;
  logic [IW:0]       r_tail;

  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_tail_idx;
  logic          w_full;
  logic          w_alloc;
  logic          w_commit;

  assign w_head_idx = r_head[IW-1:0];
  assign w_tail_idx = r_tail[IW-1:0];
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IW] != r_tail[IW]);
  assign w_alloc    = alloc_valid && !w_full && !flush;
  assign w_commit   = r_valid[w_head_idx] && r_done[w_head_idx] && !flush;

  assign alloc_ready = !w_full;
  assign alloc_tag   = w_tail_idx;
  assign count       = r_tail - r_head;
  assign commit_we   = w_commit;
  assign commit_reg  = w_commit ? r_dest[w_head_idx] : '0;
  assign commit_data = w_commit ? r_data[w_head_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_dest[w_tail_idx]  <= alloc_dest;
        r_data[w_tail_idx]  <= '0;
        r_tail              <= r_tail + 1'b1;
      end
      // The entry being allocated is still invalid here, so a same-edge wb to it drops.
      if (wb_valid && r_valid[wb_tag]) begin
        r_done[wb_tag] <= 1'b1;
        r_data[wb_tag] <= wb_data;
      end
      // Retirement is last so it wins over a stray second wb to the head entry.
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a small register file fed by the commit port.
module tb_reorder_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       alloc_valid;
  logic [1:0] alloc_dest;
  logic       alloc_ready;
  logic [1:0] alloc_tag;
  logic       wb_valid;
  logic [1:0] wb_tag;
  logic [7:0] wb_data;
  logic       commit_we;
  logic [1:0] commit_reg;
  logic [7:0] commit_data;
  logic [2:0] count;

  logic [7:0] rf [4];
  int n_chk;
  int n_err;

  reorder_buffer #(.DEPTH(4), .DATA_W(8), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .commit_we(commit_we), .commit_reg(commit_reg), .commit_data(commit_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) rf[i] = 8'h00;
  always @(posedge clk) if (commit_we) rf[commit_reg] <= commit_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; flush = 1'b0;
    alloc_valid = 1'b0; alloc_dest = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_we", commit_we, 0);
    chk("rst_reg", commit_reg, 0);
    chk("rst_data", commit_data, 0);
    #10 rst_n = 1'b1;
    tick();

    // In-order retirement despite out-of-order writeback
    alloc_valid = 1'b1; alloc_dest = 2'd1; #1;
    chk("io_tag0", alloc_tag, 0);
    tick();
    alloc_dest = 2'd2; #1;
    chk("io_tag1", alloc_tag, 1);
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 2'd1; wb_data = 8'h22; #1;
    chk("io_count2", count, 2);
    chk("io_we_none", commit_we, 0);
    tick();
    wb_tag = 2'd0; wb_data = 8'h11; #1;
    chk("io_we_wait_head", commit_we, 0);
    tick();
    wb_valid = 1'b0; #1;
    chk("io_c1_we", commit_we, 1);
    chk("io_c1_reg", commit_reg, 1);
    chk("io_c1_data", commit_data, 8'h11);
    tick();
    chk("io_rf1", rf[1], 8'h11);
    chk("io_c2_we", commit_we, 1);
    chk("io_c2_reg", commit_reg, 2);
    chk("io_c2_data", commit_data, 8'h22);
    tick();
    chk("io_done_we", commit_we, 0);
    chk("io_done_count", count, 0);
    chk("io_done_data", commit_data, 0);
    chk("io_rf2", rf[2], 8'h22);

    // Fill to capacity, refuse extra allocation, wrap the tag
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_dest = 2'(i); #1;
      chk("full_tag", alloc_tag, i);
      tick();
    end
    alloc_dest = 2'd0; #1;
    chk("full_count4", count, 4);
    chk("full_ready0", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0; #1;
    chk("full_ignored", count, 4);
    wb_valid = 1'b1; wb_tag = 2'd0; wb_data = 8'hA0;
    chk("full_we_pre", commit_we, 0);
    tick();
    wb_valid = 1'b0; alloc_valid = 1'b1; alloc_dest = 2'd3; #1;
    chk("sim_full_we", commit_we, 1);
    chk("sim_full_reg", commit_reg, 0);
    chk("sim_full_data", commit_data, 8'hA0);
    chk("sim_full_ready", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0; #1;
    chk("sim_refused_count", count, 3);
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    wb_valid = 1'b1; wb_tag = 2'd1; wb_data = 8'hB1;
    tick();
    wb_tag = 2'd2; wb_data = 8'hC2; #1;
    chk("seq_we1", commit_we, 1);
    chk("seq_data1", commit_data, 8'hB1);
    tick();
    wb_valid = 1'b0; alloc_valid = 1'b1; alloc_dest = 2'd0; #1;
    chk("sim_cnt2_pre", count, 2);
    chk("sim_cnt2_we", commit_we, 1);
    chk("sim_cnt2_reg", commit_reg, 2);
    chk("sim_cnt2_data", commit_data, 8'hC2);
    tick();
    alloc_dest = 2'd1; wb_valid = 1'b1; wb_tag = 2'd0; wb_data = 8'hD0; #1;
    chk("sim_cnt2_post", count, 2);
    chk("sim_tag1", alloc_tag, 1);
    chk("sim_head_wait", commit_we, 0);
    tick();

    // Flush overrides a ready commit and discards everything
    alloc_valid = 1'b0; wb_tag = 2'd1; wb_data = 8'hE1; #1;
    chk("fl_count3", count, 3);
    tick();
    wb_tag = 2'd3; wb_data = 8'hF3; #1;
    chk("fl_head_not_done", commit_we, 0);
    tick();
    wb_valid = 1'b0; flush = 1'b1; #1;
    chk("fl_we_forced0", commit_we, 0);
    chk("fl_data_forced0", commit_data, 0);
    tick();
    flush = 1'b0; #1;
    chk("fl_count0", count, 0);
    chk("fl_ready", alloc_ready, 1);
    chk("fl_tag", alloc_tag, 0);
    wb_valid = 1'b1; wb_tag = 2'd3; wb_data = 8'h77;
    tick();
    wb_valid = 1'b0; #1;
    chk("fl_late_wb_we", commit_we, 0);
    chk("fl_late_wb_count", count, 0);
    chk("fl_rf3_untouched", rf[3], 0);

    // No writeback-to-commit bypass
    alloc_valid = 1'b1; alloc_dest = 2'd3; #1;
    chk("bp_tag", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 2'd0; wb_data = 8'h5A; #1;
    chk("bp_we_cycleN", commit_we, 0);
    tick();
    wb_valid = 1'b0; #1;
    chk("bp_we_cycleN1", commit_we, 1);
    chk("bp_reg", commit_reg, 3);
    chk("bp_data", commit_data, 8'h5A);
    tick();
    chk("bp_rf3", rf[3], 8'h5A);
    chk("bp_count", count, 0);

    // Asynchronous reset with live entries
    for (int i = 1; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_dest = 2'(i);
      tick();
    end
    alloc_valid = 1'b0; #1;
    chk("ar_count3", count, 3);
    #2 rst_n = 1'b0; #1;
    chk("ar_count", count, 0);
    chk("ar_we", commit_we, 0);
    chk("ar_ready", alloc_ready, 1);
    chk("ar_tag", alloc_tag, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_after_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
